// File: rtl/counter_core_n.sv
// Prescaled up/down/bounce/one-shot counter with runtime limit and synchronous load.
// All outputs registered; a tick lands one edge after the prescaler match; no backpressure.
module counter_core_n #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [1:0]            mode,
   input  logic [WIDTH-1:0]      limit,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   output logic [WIDTH-1:0]      count,
   output logic                  dir,
   output logic                  tc,
   output logic                  done
);

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_ONE    = 2'b11;

   localparam logic [WIDTH-1:0]      ONE   = WIDTH'(1);
   localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] pcnt, pcnt_nxt;
   logic [WIDTH-1:0]      count_nxt;
   logic                  dir_nxt, tc_nxt, done_nxt;
   logic                  tick;

   assign tick = !load && (pcnt == prescale);

   always_comb begin
      count_nxt = count;
      dir_nxt   = dir;
      tc_nxt    = 1'b0;
      done_nxt  = done;
      pcnt_nxt  = pcnt;
      if (load) begin
         count_nxt = (load_val > limit) ? limit : load_val;
         pcnt_nxt  = '0;
         done_nxt  = 1'b0;
         dir_nxt   = (mode != MODE_DOWN);
      end else begin
         pcnt_nxt = tick ? '0 : pcnt + P_ONE;
         if (tick) begin
            case (mode)
               MODE_UP: begin
                  dir_nxt = 1'b1;
                  if (count >= limit) begin
                     count_nxt = '0;
                     tc_nxt    = 1'b1;
                  end else begin
                     count_nxt = count + ONE;
                  end
               end
               MODE_DOWN: begin
                  dir_nxt = 1'b0;
                  if (count > limit) begin
                     count_nxt = limit;
                  end else if (count == '0) begin
                     count_nxt = limit;
                     tc_nxt    = 1'b1;
                  end else begin
                     count_nxt = count - ONE;
                  end
               end
               MODE_BOUNCE: begin
                  // limit==0 pins the count at 0 while dir keeps reversing each tick
                  if (dir) begin
                     if (count >= limit) begin
                        dir_nxt   = 1'b0;
                        count_nxt = (limit == '0) ? '0 : limit - ONE;
                        tc_nxt    = 1'b1;
                     end else begin
                        count_nxt = count + ONE;
                     end
                  end else if (count > limit) begin
                     count_nxt = limit;
                     tc_nxt    = 1'b1;
                  end else if (count == '0) begin
                     dir_nxt   = 1'b1;
                     count_nxt = (limit == '0) ? '0 : ONE;
                     tc_nxt    = 1'b1;
                  end else begin
                     count_nxt = count - ONE;
                  end
               end
               MODE_ONE: begin
                  if (!done) begin
                     dir_nxt = 1'b1;
                     if (count >= limit) begin
                        count_nxt = limit;
                        done_nxt  = 1'b1;
                        tc_nxt    = 1'b1;
                     end else begin
                        count_nxt = count + ONE;
                        if (count + ONE == limit) begin
                           done_nxt = 1'b1;
                           tc_nxt   = 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         dir   <= 1'b1;
         tc    <= 1'b0;
         done  <= 1'b0;
         pcnt  <= '0;
      end else if (ena) begin
         count <= count_nxt;
         dir   <= dir_nxt;
         tc    <= tc_nxt;
         done  <= done_nxt;
         pcnt  <= pcnt_nxt;
      end else begin
         tc <= 1'b0;
      end
   end

endmodule

// File: tb/tb_counter_core_n.sv
// Directed scenarios plus random stimulus, all checked against a cycle-level reference model.
module tb_counter_core_n;

   logic       clk = 1'b0;
   logic       rst_n, ena, load;
   logic [1:0] mode;
   logic [7:0] limit, load_val;
   logic [3:0] prescale;
   logic [7:0] count;
   logic       dir, tc, done;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_count, m_pcnt;
   bit m_dir, m_tc, m_done;

   counter_core_n #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .limit(limit),
      .prescale(prescale), .load(load), .load_val(load_val),
      .count(count), .dir(dir), .tc(tc), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int lim;
      lim = int'(limit);
      if (!rst_n) begin
         m_count = 0; m_dir = 1; m_tc = 0; m_done = 0; m_pcnt = 0;
      end else if (!ena) begin
         m_tc = 0;
      end else if (load) begin
         m_count = (int'(load_val) > lim) ? lim : int'(load_val);
         m_pcnt  = 0; m_done = 0; m_tc = 0;
         m_dir   = (mode != 2'd1);
      end else begin
         bit tk;
         tk     = (m_pcnt == int'(prescale));
         m_pcnt = tk ? 0 : (m_pcnt + 1) % 16;
         m_tc   = 0;
         if (tk) begin
            case (mode)
               2'd0: begin
                  m_dir = 1;
                  if (m_count >= lim) begin m_count = 0; m_tc = 1; end
                  else m_count = m_count + 1;
               end
               2'd1: begin
                  m_dir = 0;
                  if (m_count > lim) m_count = lim;
                  else if (m_count == 0) begin m_count = lim; m_tc = 1; end
                  else m_count = m_count - 1;
               end
               2'd2: begin
                  if (m_dir) begin
                     if (m_count >= lim) begin
                        m_dir = 0; m_tc = 1;
                        m_count = (lim == 0) ? 0 : lim - 1;
                     end else m_count = m_count + 1;
                  end else if (m_count > lim) begin
                     m_count = lim; m_tc = 1;
                  end else if (m_count == 0) begin
                     m_dir = 1; m_tc = 1;
                     m_count = (lim == 0) ? 0 : 1;
                  end else m_count = m_count - 1;
               end
               default: begin
                  if (!m_done) begin
                     m_dir = 1;
                     if (m_count < lim) m_count = m_count + 1;
                     else m_count = lim;
                     if (m_count == lim) begin m_done = 1; m_tc = 1; end
                  end
               end
            endcase
         end
      end
   endtask

   // one clock: advance model with the inputs present at the edge, then compare
   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check({tag, "_count"}, 32'(count), 32'(m_count));
      check({tag, "_dir"},   32'(dir),   32'(m_dir));
      check({tag, "_tc"},    32'(tc),    32'(m_tc));
      check({tag, "_done"},  32'(done),  32'(m_done));
   endtask

   task automatic do_load(input logic [1:0] md, input logic [7:0] lim, input logic [7:0] val);
      mode = md; limit = lim; load_val = val; load = 1;
      cyc("load");
      load = 0;
   endtask

   initial begin
      int exp1 [6];
      int exp3 [6];
      int tcs;
      rst_n = 0; ena = 1; load = 0; mode = 0; limit = 5; prescale = 0; load_val = 0;

      // 1: reset then up-wrap 0..5
      #1;
      cyc("rst"); cyc("rst");
      check("rst_count", 32'(count), 32'd0);
      check("rst_dir",   32'(dir),   32'd1);
      rst_n = 1;
      exp1 = '{1, 2, 3, 4, 5, 0};
      for (int i = 0; i < 6; i++) begin
         cyc("t1");
         check("t1_seq", 32'(count), 32'(exp1[i]));
         check("t1_tc",  32'(tc), (i == 5) ? 32'd1 : 32'd0);
      end
      cyc("t1"); check("t1_after", 32'(count), 32'd1);

      // 2: down-wrap with saturating load
      do_load(2'd1, 8'd3, 8'd9);
      check("t2_sat", 32'(count), 32'd3);
      check("t2_dir", 32'(dir), 32'd0);
      for (int i = 0; i < 4; i++) cyc("t2");
      check("t2_wrap", 32'(count), 32'd3);
      check("t2_tc",   32'(tc), 32'd1);

      // 3: bounce
      do_load(2'd2, 8'd2, 8'd0);
      exp3 = '{1, 2, 1, 0, 1, 2};
      for (int i = 0; i < 6; i++) begin
         cyc("t3");
         check("t3_seq", 32'(count), 32'(exp3[i]));
      end

      // 4: one-shot with prescale 2
      prescale = 2;
      do_load(2'd3, 8'd4, 8'd0);
      tcs = 0;
      for (int i = 0; i < 32; i++) begin
         cyc("t4");
         if (tc) tcs++;
      end
      check("t4_final", 32'(count), 32'd4);
      check("t4_done",  32'(done), 32'd1);
      check("t4_tcs",   32'(tcs), 32'd1);
      do_load(2'd3, 8'd4, 8'd0);
      check("t4_clr", 32'(done), 32'd0);

      // 5: limit drops below count; ena=0 holds
      prescale = 0;
      do_load(2'd0, 8'd200, 8'd150);
      limit = 100;
      cyc("t5");
      check("t5_wrap", 32'(count), 32'd0);
      check("t5_tc",   32'(tc), 32'd1);
      cyc("t5"); cyc("t5");
      ena = 0;
      for (int i = 0; i < 3; i++) cyc("t5h");
      check("t5_hold", 32'(count), 32'd2);
      check("t5_tc0",  32'(tc), 32'd0);
      ena = 1;

      // 6: reset mid-bounce at count 7 going down
      do_load(2'd2, 8'd8, 8'd0);
      for (int i = 0; i < 9; i++) cyc("t6");
      check("t6_pre",  32'(count), 32'd7);
      check("t6_pdir", 32'(dir), 32'd0);
      rst_n = 0;
      cyc("t6r");
      check("t6_count", 32'(count), 32'd0);
      check("t6_dir",   32'(dir), 32'd1);
      rst_n = 1;

      // random phase
      for (int i = 0; i < 3000; i++) begin
         rst_n    = ($urandom_range(0, 199) != 0);
         ena      = ($urandom_range(0, 9) != 0);
         load     = ($urandom_range(0, 24) == 0);
         load_val = 8'($urandom);
         if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 39) == 0)
            limit = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         if ($urandom_range(0, 59) == 0) prescale = 4'($urandom_range(0, 3));
         cyc("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
